// File: rtl/conv_frame_tx.sv
// Tags the decimated convolution pixel stream with sof/eol/eof frame position and
// buffers the tagged pixels in a show-ahead FIFO that feeds a ready/valid consumer.
module conv_frame_tx #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 180,
    parameter int DEPTH  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    input  logic [7:0]               pixel_i,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic [7:0]               m_data_o,
    output logic                     m_sof_o,
    output logic                     m_eol_o,
    output logic                     m_eof_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic [15:0]              drop_cnt_o,
    output logic [15:0]              frame_cnt_o,
    output logic                     frame_done_o,
    output logic                     fsm_state
);

    // Output handshake: an entry moves from the FIFO head to the consumer on every
    // rising edge where m_valid_o && m_ready_i; m_valid_o never waits for m_ready_i,
    // and the head (data and tags) holds while m_valid_o && !m_ready_i.

    localparam int AW = $clog2(DEPTH);
    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic            tag_sof, tag_eol, tag_eof;

    logic [10:0]     mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [10:0]     head;
    logic            full, push, pop, drop;

    assign tag_sof = (x_q == '0) && (y_q == '0);
    assign tag_eol = (x_q == XW'(WIDTH - 1));
    assign tag_eof = tag_eol && (y_q == YW'(HEIGHT - 1));

    // Position advances on every input pixel, dropped or not, so tags stay aligned.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        if (valid_i) begin
            if (tag_eol) begin
                x_d = '0;
                y_d = tag_eof ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
            case (state_q)
                IDLE:    if (!tag_eof) state_d = ACTIVE;
                ACTIVE:  if (tag_eof)  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign fsm_state = (state_q == ACTIVE);

    assign full      = (level_o == (AW + 1)'(DEPTH));
    assign m_valid_o = (level_o != '0);
    assign pop       = m_valid_o && m_ready_i;
    assign push      = valid_i && (!full || pop);
    assign drop      = valid_i && full && !pop;

    // Storage needs no reset: outputs are forced to zero while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {tag_eof, tag_eol, tag_sof, pixel_i};
        end
    end

    assign head     = mem[rd_ptr];
    assign m_data_o = m_valid_o ? head[7:0] : 8'h00;
    assign m_sof_o  = m_valid_o && head[8];
    assign m_eol_o  = m_valid_o && head[9];
    assign m_eof_o  = m_valid_o && head[10];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            level_o      <= '0;
            overflow_o   <= 1'b0;
            drop_cnt_o   <= 16'h0000;
            frame_cnt_o  <= 16'h0000;
            frame_done_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                level_o <= level_o + 1'b1;
            end else if (pop && !push) begin
                level_o <= level_o - 1'b1;
            end
            if (drop) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'h0001;
            end
            frame_done_o <= pop && head[10];
            if (pop && head[10]) frame_cnt_o <= frame_cnt_o + 16'h0001;
        end
    end

endmodule

// File: tb/tb_conv_frame_tx.sv
// Bench for conv_frame_tx: a small frame geometry keeps runs short; a queue-based
// reference model of the tagged FIFO is checked every cycle on the falling edge.
module tb_conv_frame_tx;

    localparam int W  = 20;
    localparam int H  = 5;
    localparam int D  = 16;
    localparam int FR = W * H;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  pixel = 8'h00;
    logic        rdy = 1'b0;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_sof, m_eol, m_eof;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic [15:0] frame_cnt;
    logic        frame_done;
    logic        fsm_state;

    conv_frame_tx #(.WIDTH(W), .HEIGHT(H), .DEPTH(D)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .pixel_i(pixel),
        .m_valid_o(m_valid), .m_ready_i(rdy), .m_data_o(m_data),
        .m_sof_o(m_sof), .m_eol_o(m_eol), .m_eof_o(m_eof),
        .level_o(level), .overflow_o(overflow), .drop_cnt_o(drop_cnt),
        .frame_cnt_o(frame_cnt), .frame_done_o(frame_done), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [10:0] exp_q[$];
    int          pos = 0;
    logic [15:0] exp_drop = 0;
    logic [15:0] exp_frames = 0;
    logic        exp_ovf = 0;
    logic        exp_done = 0;
    bit          model_on = 0;
    bit          prev_stall = 0;
    logic [10:0] prev_head = 0;
    logic [10:0] new_entry;
    logic [4:0]  exp_lvl;
    bit          pop_m;
    int          done_seen = 0;
    int          n_pops = 0, n_sof = 0, n_eol = 0, n_eof = 0;

    always @(negedge clk) begin
        if (model_on) begin
            exp_lvl = 5'(exp_q.size());
            total++;
            if (m_valid !== (exp_q.size() != 0)) begin
                bad++; $display("FAIL m_valid got=%b exp=%b", m_valid, exp_q.size() != 0);
            end
            total++;
            if (level !== exp_lvl) begin
                bad++; $display("FAIL level got=%0d exp=%0d", level, exp_lvl);
            end
            total++;
            if (overflow !== exp_ovf || drop_cnt !== exp_drop) begin
                bad++; $display("FAIL ovf_drop got=%b/%0d exp=%b/%0d", overflow, drop_cnt, exp_ovf, exp_drop);
            end
            total++;
            if (frame_cnt !== exp_frames || frame_done !== exp_done) begin
                bad++; $display("FAIL frames got=%0d/%b exp=%0d/%b", frame_cnt, frame_done, exp_frames, exp_done);
            end
            total++;
            if (fsm_state !== (pos != 0)) begin
                bad++; $display("FAIL fsm_state got=%b exp=%b", fsm_state, pos != 0);
            end
            if (exp_q.size() != 0) begin
                total++;
                if ({m_eof, m_eol, m_sof, m_data} !== exp_q[0]) begin
                    bad++; $display("FAIL head got=%h exp=%h", {m_eof, m_eol, m_sof, m_data}, exp_q[0]);
                end
            end
            if (prev_stall) begin
                total++;
                if ({m_eof, m_eol, m_sof, m_data} !== prev_head) begin
                    bad++; $display("FAIL stall_hold got=%h exp=%h", {m_eof, m_eol, m_sof, m_data}, prev_head);
                end
            end
            if (frame_done === 1'b1) done_seen++;
            if (m_valid === 1'b1 && rdy) begin
                n_pops++;
                if (m_sof) n_sof++;
                if (m_eol) n_eol++;
                if (m_eof) n_eof++;
            end
        end
        // advance the model across the coming rising edge
        if (rst) begin
            exp_q.delete();
            pos = 0; exp_drop = 0; exp_frames = 0; exp_ovf = 0; exp_done = 0;
            prev_stall = 0; model_on = 1;
        end else if (model_on) begin
            pop_m = (exp_q.size() != 0) && rdy;
            prev_stall = (exp_q.size() != 0) && !rdy;
            prev_head = {m_eof, m_eol, m_sof, m_data};
            exp_done = 0;
            if (pop_m) begin
                if (exp_q[0][10]) begin
                    exp_done = 1;
                    exp_frames = exp_frames + 16'd1;
                end
                void'(exp_q.pop_front());
            end
            if (valid) begin
                new_entry = {pos == FR - 1, (pos % W) == W - 1, pos == 0, pixel};
                if (exp_q.size() < D) begin
                    exp_q.push_back(new_entry);
                end else begin
                    exp_ovf = 1;
                    if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
                end
                pos = (pos + 1) % FR;
            end
        end
    end

    task automatic drive(input logic r, input logic v, input logic [7:0] p, input logic rd);
        rst = r; valid = v; pixel = p; rdy = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 8'hA5, 1'b0);
        drive(1'b1, 1'b1, 8'h5A, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        total++;
        if (m_valid !== 1'b0 || level !== 5'd0) begin
            bad++; $display("FAIL reset_fifo got=%b/%0d exp=0/0", m_valid, level);
        end
        total++;
        if ({m_data, m_sof, m_eol, m_eof} !== 11'd0) begin
            bad++; $display("FAIL reset_head got=%h exp=0", {m_data, m_sof, m_eol, m_eof});
        end
        total++;
        if (overflow !== 1'b0 || drop_cnt !== 16'd0 || frame_cnt !== 16'd0 || frame_done !== 1'b0) begin
            bad++; $display("FAIL reset_stat got=%b/%0d/%0d/%b exp=0", overflow, drop_cnt, frame_cnt, frame_done);
        end
        total++;
        if (fsm_state !== 1'b0) begin
            bad++; $display("FAIL reset_fsm got=%b exp=0", fsm_state);
        end
    endtask

    task automatic test_full_frame();
        done_seen = 0; n_pops = 0; n_sof = 0; n_eol = 0; n_eof = 0;
        for (int i = 0; i < FR; i++) begin
            drive(1'b0, 1'b1, 8'(i % 256), 1'b1);
            if (i == 0) begin
                total++;
                if (m_valid !== 1'b1 || m_data !== 8'd0 || m_sof !== 1'b1) begin
                    bad++; $display("FAIL latency got=%b/%h/%b exp=1/00/1", m_valid, m_data, m_sof);
                end
            end
        end
        drain(3);
        total++;
        if (n_pops != FR || n_sof != 1 || n_eol != H || n_eof != 1) begin
            bad++; $display("FAIL frame_tags got=%0d/%0d/%0d/%0d exp=%0d/1/%0d/1", n_pops, n_sof, n_eol, n_eof, FR, H);
        end
        total++;
        if (frame_cnt !== 16'd1 || done_seen != 1 || drop_cnt !== 16'd0) begin
            bad++; $display("FAIL frame_done got=%0d/%0d/%0d exp=1/1/0", frame_cnt, done_seen, drop_cnt);
        end
    endtask

    task automatic test_overflow();
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
        total++;
        if (level !== 5'd16 || overflow !== 1'b1 || drop_cnt !== 16'd4) begin
            bad++; $display("FAIL overflow got=%0d/%b/%0d exp=16/1/4", level, overflow, drop_cnt);
        end
        n_pops = 0;
        drain(20);
        total++;
        if (n_pops != 16) begin
            bad++; $display("FAIL ovf_drain got=%0d exp=16", n_pops);
        end
        for (int i = 20; i < FR; i++) drive(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
        drive(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
        total++;
        if (m_valid !== 1'b1 || m_sof !== 1'b1) begin
            bad++; $display("FAIL ovf_next_sof got=%b/%b exp=1/1", m_valid, m_sof);
        end
        drain(3);
    endtask

    task automatic test_full_pushpop();
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
        total++;
        if (level !== 5'd16) begin
            bad++; $display("FAIL fill got=%0d exp=16", level);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
            total++;
            if (level !== 5'd16) begin
                bad++; $display("FAIL full_pushpop_level got=%0d exp=16", level);
            end
        end
        total++;
        if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin
            bad++; $display("FAIL full_pushpop_drop got=%0d/%b exp=0/0", drop_cnt, overflow);
        end
        drain(20);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < FR; i++) drive(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
        for (int i = 0; i < 37; i++) drive(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        drive(1'b1, 1'b1, 8'h77, 1'b1);
        total++;
        if (frame_cnt !== 16'd0 || m_valid !== 1'b0) begin
            bad++; $display("FAIL mid_reset got=%0d/%b exp=0/0", frame_cnt, m_valid);
        end
        for (int i = 0; i < FR; i++) begin
            drive(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
            if (i == 0) begin
                total++;
                if (m_valid !== 1'b1 || m_sof !== 1'b1) begin
                    bad++; $display("FAIL mid_reset_sof got=%b/%b exp=1/1", m_valid, m_sof);
                end
            end
        end
        drain(3);
        total++;
        if (frame_cnt !== 16'd1) begin
            bad++; $display("FAIL mid_reset_frames got=%0d exp=1", frame_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int sel;
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        done_seen = 0;
        for (int i = 0; i < 2 * FR; i++) begin
            sel = $urandom_range(0, 1);
            drive(1'b0, 1'b1, 8'($urandom_range(0, 255)), sel == 0);
            drive(1'b0, 1'b0, 8'h00, sel == 1);
        end
        drain(20);
        total++;
        if (frame_cnt !== 16'd2 || done_seen != 2) begin
            bad++; $display("FAIL b2b_frames got=%0d/%0d exp=2/2", frame_cnt, done_seen);
        end
        total++;
        if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin
            bad++; $display("FAIL b2b_drop got=%0d/%b exp=0/0", drop_cnt, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_overflow();
        test_full_pushpop();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
